// File: rtl/comp_scheduler.sv
// Round-robin scheduler sharing one sign-magnitude combine unit (meas - refw) among NCH requesters.
// Each grant is captured, combined, and then held as a result until the downstream accepts it.
module comp_scheduler #(
    parameter int DATA_W = 24,
    parameter int NCH    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*DATA_W-1:0] meas,
    input  logic [NCH*DATA_W-1:0] refw,
    output logic [NCH-1:0]        ack,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_ch,
    output logic                  out_sat
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MW = DATA_W - 1;

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
    state_t state, state_nx;

    logic [GW-1:0]     last_grant, grant, hi_idx, lo_idx;
    logic              hi_found, lo_found, grant_found;
    logic [DATA_W-1:0] sel_meas, sel_refw, cap_meas, cap_refw;
    logic              capture, load, accept;

    // Round robin: the lowest requesting channel above last_grant wins, otherwise wrap to the lowest one.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        sel_meas = '0;
        sel_refw = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (GW'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_idx   = GW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = GW'(i);
                end
            end
        end
        grant_found = hi_found | lo_found;
        grant       = hi_found ? hi_idx : lo_idx;
        for (int i = 0; i < NCH; i++) begin
            if (GW'(i) == grant) begin
                sel_meas = meas[i*DATA_W +: DATA_W];
                sel_refw = refw[i*DATA_W +: DATA_W];
            end
        end
    end

    logic          a_sign, b_sign, res_sign, res_sat;
    logic [MW-1:0] a_mag, b_mag, res_mag;
    logic [MW:0]   mag_sum;

    // The reference sign is flipped, so the unit computes meas + (-refw).
    always_comb begin
        a_sign   = cap_meas[DATA_W-1];
        a_mag    = cap_meas[MW-1:0];
        b_sign   = ~cap_refw[DATA_W-1];
        b_mag    = cap_refw[MW-1:0];
        mag_sum  = {1'b0, a_mag} + {1'b0, b_mag};
        res_sign = 1'b0;
        res_mag  = '0;
        res_sat  = 1'b0;
        if (a_sign == b_sign) begin
            res_sign = a_sign;
            if (mag_sum[MW]) begin
                res_mag = '1;
                res_sat = 1'b1;
            end else begin
                res_mag = mag_sum[MW-1:0];
            end
        end else if (a_mag >= b_mag) begin
            res_sign = a_sign;
            res_mag  = a_mag - b_mag;
        end else begin
            res_sign = b_sign;
            res_mag  = b_mag - a_mag;
        end
        if (res_mag == '0) res_sign = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_found) state_nx = CALC;
            CALC:    state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        capture = (state == IDLE) && grant_found;
        load    = (state == CALC);
        accept  = (state == OUT) && out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GW'(NCH - 1);
            cap_meas   <= '0;
            cap_refw   <= '0;
            ack        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_sat    <= 1'b0;
        end else begin
            ack <= '0;
            if (capture) begin
                cap_meas   <= sel_meas;
                cap_refw   <= sel_refw;
                last_grant <= grant;
                ack        <= NCH'(1) << grant;
            end
            if (load) begin
                out_data  <= {res_sign, res_mag};
                out_ch    <= 2'(last_grant);
                out_sat   <= res_sat;
                out_valid <= 1'b1;
            end
            if (accept) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_comp_scheduler.sv
// Bench for comp_scheduler: vector table through a scoreboard, then stall/round-robin and mid-op reset sequences.
module tb_comp_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [71:0] meas = '0;
    logic [71:0] refw = '0;
    logic [2:0]  ack;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_data;
    logic [1:0]  out_ch;
    logic        out_sat;

    int compares = 0;
    int errors   = 0;

    comp_scheduler #(.DATA_W(24), .NCH(3)) dut (
        .clk(clk), .rst(rst), .req(req), .meas(meas), .refw(refw), .ack(ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [23:0] m;
        logic [23:0] r;
        logic [23:0] d;
        logic        s;
    } vec_t;

    typedef struct {
        logic [23:0] d;
        logic [1:0]  ch;
        logic        s;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [23:0] d, input int ch, input logic s);
        exp_t e;
        e.d  = d;
        e.ch = 2'(ch);
        e.s  = s;
        sb.push_back(e);
    endtask

    task automatic pop_check(output exp_t e);
        e = '{24'h0, 2'd0, 1'b0};
        if (sb.size() == 0) begin
            compares++;
            errors++;
            $display("FAIL scoreboard_empty: got output %0h required no output", out_data);
        end else begin
            e = sb.pop_front();
            check("out_data", 32'(out_data), 32'(e.d));
            check("out_ch", 32'(out_ch), 32'(e.ch));
            check("out_sat", 32'(out_sat), 32'(e.s));
        end
    endtask

    task automatic wait_ack(output logic [2:0] got);
        int n = 0;
        while (ack == 3'b000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        got = ack;
        if (ack == 3'b000) begin
            compares++;
            errors++;
            $display("FAIL ack_timeout: got no ack required ack within 20 cycles");
        end
    endtask

    // At most one ack bit may ever be high.
    always @(negedge clk) begin
        if (!rst) begin
            compares++;
            if (!$onehot0(ack)) begin
                errors++;
                $display("FAIL ack_onehot: got %b required at most one bit", ack);
            end
        end
    end

    initial begin
        logic [2:0] got;
        exp_t       e;

        vecs[0] = '{0, 24'h000100, 24'h000040, 24'h0000C0, 1'b0};
        vecs[1] = '{1, 24'h000010, 24'h000030, 24'h800020, 1'b0};
        vecs[2] = '{2, 24'h000050, 24'h000050, 24'h000000, 1'b0};
        vecs[3] = '{0, 24'h800000, 24'h000000, 24'h000000, 1'b0};
        vecs[4] = '{1, 24'h7FFFFF, 24'h800001, 24'h7FFFFF, 1'b1};
        vecs[5] = '{2, 24'h800010, 24'h000010, 24'h800020, 1'b0};
        vecs[6] = '{0, 24'h800005, 24'h800009, 24'h000004, 1'b0};
        vecs[7] = '{1, 24'hFFFFFF, 24'h7FFFFF, 24'hFFFFFF, 1'b1};
        vecs[8] = '{2, 24'h000000, 24'h800000, 24'h000000, 1'b0};
        vecs[9] = '{0, 24'h000003, 24'h000000, 24'h000003, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_ch", 32'(out_ch), 32'h0);
        check("rst_sat", 32'(out_sat), 32'h0);
        rst = 1'b0;

        foreach (vecs[v]) begin
            @(negedge clk);
            meas = '0;
            refw = '0;
            meas[vecs[v].ch*24 +: 24] = vecs[v].m;
            refw[vecs[v].ch*24 +: 24] = vecs[v].r;
            req = 3'b001 << vecs[v].ch;
            push_exp(vecs[v].d, vecs[v].ch, vecs[v].s);
            wait_ack(got);
            check("vec_ack", 32'(got), 32'(3'b001 << vecs[v].ch));
            req = '0;
            @(negedge clk);
            check("vec_ack_one_cycle", 32'(ack), 32'h0);
            check("vec_latency_valid", 32'(out_valid), 32'h1);
            pop_check(e);
            @(negedge clk);
            check("vec_valid_drop", 32'(out_valid), 32'h0);
        end

        // All channels requesting with a stalled consumer: grants rotate 0,1,2,0 and results hold.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        meas = {24'h000003, 24'h000002, 24'h000001};
        refw = '0;
        req = 3'b111;
        push_exp(24'h000001, 0, 1'b0);
        push_exp(24'h000002, 1, 1'b0);
        push_exp(24'h000003, 2, 1'b0);
        push_exp(24'h000001, 0, 1'b0);
        for (int g = 0; g < 4; g++) begin
            wait_ack(got);
            check("rr_ack", 32'(got), 32'(3'b001 << (g % 3)));
            @(negedge clk);
            check("rr_valid", 32'(out_valid), 32'h1);
            pop_check(e);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check("stall_valid", 32'(out_valid), 32'h1);
                check("stall_data", 32'(out_data), 32'(e.d));
                check("stall_ch", 32'(out_ch), 32'(e.ch));
                check("stall_ack", 32'(ack), 32'h0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("rr_accept", 32'(out_valid), 32'h0);
        end

        // Reset during CALC of the ch1 grant aborts it and restores ch0 priority.
        wait_ack(got);
        check("abort_ack", 32'(got), 32'h2);
        rst = 1'b1;
        #1;
        check("abort_rst_ack", 32'(ack), 32'h0);
        check("abort_rst_valid", 32'(out_valid), 32'h0);
        check("abort_rst_data", 32'(out_data), 32'h0);
        check("abort_rst_ch", 32'(out_ch), 32'h0);
        check("abort_rst_sat", 32'(out_sat), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        push_exp(24'h000001, 0, 1'b0);
        wait_ack(got);
        check("abort_regrant", 32'(got), 32'h1);
        check("abort_no_valid", 32'(out_valid), 32'h0);
        req = '0;
        @(negedge clk);
        check("abort_new_valid", 32'(out_valid), 32'h1);
        pop_check(e);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end
endmodule
